// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared sizes, FSM states and memory-access functions for pmem_port
package pmem_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

   // Offset bits that must be zero for a naturally aligned access of this size
   function automatic logic [2:0] size_lowmask(input size_e s);
      case (s)
         SZ_B:    return 3'b000;
         SZ_H:    return 3'b001;
         SZ_W:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   logic [63:0] mem_model [logic [63:0]];
   int unsigned rd_calls = 0;
   int unsigned wr_calls = 0;
   logic [63:0] last_waddr = '0;
   logic [63:0] last_wdata = '0;
   logic [7:0]  last_wmask = '0;

   function automatic void pmem_read(input longint raddr, output longint rdata);
      rd_calls++;
      rdata = mem_model.exists(raddr) ? mem_model[raddr] : 64'd0;
   endfunction

   function automatic void pmem_write(input longint waddr, input longint wdata, input byte wmask);
      logic [63:0] cur;
      cur = mem_model.exists(waddr) ? mem_model[waddr] : 64'd0;
      for (int b = 0; b < 8; b++)
         if (wmask[b]) cur[8*b +: 8] = wdata[8*b +: 8];
      mem_model[waddr] = cur;
      wr_calls++;
      last_waddr = waddr;
      last_wdata = wdata;
      last_wmask = wmask;
   endfunction

endpackage

// File: rtl/pmem_lane.sv
// rtl/pmem_lane.sv - byte-lane alignment: store mask/shift and load shift/extension
module pmem_lane
   import pmem_pkg::*;
(
   input  size_e              size,
   input  logic [2:0]         off,
   input  logic               is_unsigned,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [DATA_W-1:0]  rdata_raw,
   output logic [7:0]         wmask,
   output logic [DATA_W-1:0]  wdata_sh,
   output logic [DATA_W-1:0]  rdata_ext
);

   logic [7:0]        mask_base;
   logic [DATA_W-1:0] rsh;

   always_comb begin
      case (size)
         SZ_B:    mask_base = 8'h01;
         SZ_H:    mask_base = 8'h03;
         SZ_W:    mask_base = 8'h0F;
         default: mask_base = 8'hFF;
      endcase
      wmask    = mask_base << off;
      wdata_sh = wdata << {off, 3'b000};
      rsh      = rdata_raw >> {off, 3'b000};
      case (size)
         SZ_B:    rdata_ext = is_unsigned ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
         SZ_H:    rdata_ext = is_unsigned ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
         SZ_W:    rdata_ext = is_unsigned ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
         default: rdata_ext = rsh;
      endcase
   end

endmodule

// File: rtl/pmem_port.sv
// rtl/pmem_port.sv - handshaked physical-memory port with programmable access latency
// PMEM_ALIGN_CHECK_EN reports misaligned requests instead of silently aligning them.
module pmem_port
   import pmem_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [1:0]         req_size,
   input  logic               req_unsigned,
   input  logic [DATA_W-1:0]  req_wdata,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [DATA_W-1:0]  resp_rdata,
   output logic               resp_err
);

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   size_e               size_q, size_d;
   logic                uns_q, uns_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   raw_q;

   logic                access;
   logic                do_access;
   logic [63:0]         addr64, aligned;
   logic [2:0]          off, off_eff, lowmask;
   logic                misaligned;
   logic [7:0]          lane_mask;
   logic [DATA_W-1:0]   lane_wdata, lane_rdata;

   assign addr64  = 64'(addr_q);
   assign aligned = {addr64[63:3], 3'b000};
   assign off     = addr64[2:0];
   assign lowmask = size_lowmask(size_q);

`ifdef PMEM_ALIGN_CHECK_EN
   assign misaligned = |(off & lowmask);
   assign off_eff    = off;
`else
   assign misaligned = 1'b0;
   assign off_eff    = off & ~lowmask;
`endif

   pmem_lane u_lane (
      .size        (size_q),
      .off         (off_eff),
      .is_unsigned (uns_q),
      .wdata       (wdata_q),
      .rdata_raw   (raw_q),
      .wmask       (lane_mask),
      .wdata_sh    (lane_wdata),
      .rdata_ext   (lane_rdata)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      size_d     = size_q;
      uns_d      = uns_q;
      wdata_d    = wdata_q;
      access     = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               size_d  = size_e'(req_size);
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               cnt_d   = 8'(LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign do_access = access && !misaligned;

   // Memory side effects happen here exactly once, on the single WAIT->RESP edge
   always_ff @(posedge clk or posedge rst) begin : seq_p
      longint rd_word;
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         raw_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         if (do_access) begin
            if (we_q) begin
               pmem_write(longint'(aligned), longint'(lane_wdata), byte'(lane_mask));
            end else begin
               pmem_read(longint'(aligned), rd_word);
               raw_q <= 64'(rd_word);
            end
         end
      end
   end

   assign resp_rdata = (state_q == RESP && !we_q && !misaligned) ? lane_rdata : '0;
   assign resp_err   = (state_q == RESP) && misaligned;

endmodule

// File: tb/tb_pmem_port.sv
// tb/tb_pmem_port.sv - scoreboard bench for pmem_port at LATENCY 2, 4 and 0
module tb_pmem_port;
   import pmem_pkg::*;

   localparam int LAT [3] = '{2, 4, 0};

   logic        clk = 1'b0;
   logic        rst          [3];
   logic        req_valid    [3];
   logic        req_ready    [3];
   logic        req_we       [3];
   logic [63:0] req_addr     [3];
   logic [1:0]  req_size     [3];
   logic        req_unsigned [3];
   logic [63:0] req_wdata    [3];
   logic        resp_valid   [3];
   logic        resp_ready   [3];
   logic [63:0] resp_rdata   [3];
   logic        resp_err     [3];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      int          idx;
      logic [63:0] rdata;
      logic        err;
   } exp_t;
   exp_t exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pmem_port #(.ADDR_W(64), .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
      .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
      .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

   pmem_port #(.ADDR_W(64), .LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
      .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
      .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

   pmem_port #(.ADDR_W(64), .LATENCY(0)) u_l0 (
      .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
      .req_unsigned(req_unsigned[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
      .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: one pop per completed response handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!rst[i] && resp_valid[i] && resp_ready[i]) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL sb_unexpected_resp: inst %0d rdata %h with empty scoreboard", i, resp_rdata[i]);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_inst", 64'(i), 64'(e.idx));
                  chk("sb_rdata", resp_rdata[i], e.rdata);
                  chk("sb_err", {63'd0, resp_err[i]}, {63'd0, e.err});
               end
            end
         end
      end
   end

   task automatic do_req(input int i, input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata, input logic [63:0] exp_rd,
                         input logic exp_err, input int hold, output int acc_cyc);
      exp_t e;
      int n;
      logic [63:0] snap;
      int unsigned calls;
      @(negedge clk);
      req_we[i] = we; req_addr[i] = addr; req_size[i] = size;
      req_unsigned[i] = uns; req_wdata[i] = wdata;
      req_valid[i] = 1'b1;
      resp_ready[i] = (hold == 0);
      e.idx = i; e.rdata = we ? 64'd0 : exp_rd; e.err = exp_err;
      exp_q.push_back(e);
      n = 0;
      while (!req_ready[i] && n < 50) begin @(negedge clk); n++; end
      chk("req_ready_idle", {63'd0, req_ready[i]}, 64'd1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      req_valid[i] = 1'b0;
      req_we[i] = ~we; req_addr[i] = ~addr; req_size[i] = ~size;
      req_unsigned[i] = ~uns; req_wdata[i] = ~wdata;
      n = 0;
      while (!resp_valid[i] && n < 300) begin @(posedge clk); #1; n++; end
      chk("latency", 64'(n), 64'(LAT[i] + 1));
      chk("req_ready_in_resp", {63'd0, req_ready[i]}, 64'd0);
      if (hold > 0) begin
         snap  = resp_rdata[i];
         calls = rd_calls + wr_calls;
         repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, resp_valid[i]}, 64'd1);
            chk("hold_rdata", resp_rdata[i], snap);
            chk("hold_req_ready", {63'd0, req_ready[i]}, 64'd0);
         end
         chk("hold_no_repeat_call", 64'(rd_calls + wr_calls), 64'(calls));
         resp_ready[i] = 1'b1;
      end
      @(posedge clk); #1;
      chk("valid_after_hs", {63'd0, resp_valid[i]}, 64'd0);
      chk("ready_after_hs", {63'd0, req_ready[i]}, 64'd1);
   endtask

   initial begin
      int a0, a1;
      int unsigned rc, wc;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
         req_size[i] = '0; req_unsigned[i] = 1'b0; req_wdata[i] = '0; resp_ready[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_req_ready", {63'd0, req_ready[i]}, 64'd1);
         chk("rst_resp_valid", {63'd0, resp_valid[i]}, 64'd0);
         chk("rst_resp_rdata", resp_rdata[i], 64'd0);
         chk("rst_resp_err", {63'd0, resp_err[i]}, 64'd0);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;

      // Store/load double, LATENCY 2
      wc = wr_calls;
      do_req(0, 1'b1, 64'h8000_0000, 2'd3, 1'b0, 64'h1122334455667788, 64'd0, 1'b0, 0, a0);
      chk("st_d_calls", 64'(wr_calls), 64'(wc + 1));
      chk("st_d_addr", last_waddr, 64'h8000_0000);
      chk("st_d_mask", {56'd0, last_wmask}, 64'hFF);
      do_req(0, 1'b0, 64'h8000_0000, 2'd3, 1'b1, 64'd0, 64'h1122334455667788, 1'b0, 0, a0);

      // Byte store at offset 3, then signed and unsigned byte loads
      do_req(0, 1'b1, 64'h8000_0003, 2'd0, 1'b0, 64'hF0, 64'd0, 1'b0, 0, a0);
      chk("st_b_addr", last_waddr, 64'h8000_0000);
      chk("st_b_mask", {56'd0, last_wmask}, 64'h08);
      chk("st_b_data", last_wdata, 64'hF000_0000);
      do_req(0, 1'b0, 64'h8000_0003, 2'd0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 0, a0);
      do_req(0, 1'b0, 64'h8000_0003, 2'd0, 1'b1, 64'd0, 64'h0000_0000_0000_00F0, 1'b0, 0, a0);

      // Back-pressure for 10 cycles
      rc = rd_calls;
      do_req(0, 1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'd0, 64'h11223344F0667788, 1'b0, 10, a0);
      chk("bp_read_once", 64'(rd_calls), 64'(rc + 1));

      // Reset in WAIT, LATENCY 4
      wc = wr_calls;
      @(negedge clk);
      req_we[1] = 1'b1; req_addr[1] = 64'h8000_0010; req_size[1] = 2'd3;
      req_wdata[1] = 64'hCAFE_BABE_DEAD_BEEF; req_valid[1] = 1'b1;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b1;
      #1;
      chk("rst_wait_req_ready", {63'd0, req_ready[1]}, 64'd1);
      chk("rst_wait_resp_valid", {63'd0, resp_valid[1]}, 64'd0);
      @(negedge clk);
      rst[1] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("rst_wait_no_write", 64'(wr_calls), 64'(wc));
      chk("rst_wait_idle_valid", {63'd0, resp_valid[1]}, 64'd0);
      do_req(1, 1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 64'd0, 1'b0, 0, a0);

      // Misaligned word load, LATENCY 0
      rc = rd_calls;
`ifdef PMEM_ALIGN_CHECK_EN
      do_req(2, 1'b0, 64'h8000_0002, 2'd2, 1'b0, 64'd0, 64'd0, 1'b1, 0, a0);
      chk("misalign_calls", 64'(rd_calls), 64'(rc));
`else
      do_req(2, 1'b0, 64'h8000_0002, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_F066_7788, 1'b0, 0, a0);
      chk("misalign_calls", 64'(rd_calls), 64'(rc + 1));
`endif

      // Back-to-back loads, LATENCY 0
      do_req(2, 1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'd0, 64'h11223344F0667788, 1'b0, 0, a0);
      do_req(2, 1'b0, 64'h8000_0004, 2'd1, 1'b1, 64'd0, 64'h0000_0000_0000_3344, 1'b0, 0, a1);
      chk("b2b_spacing", 64'(a1 - a0), 64'd3);

      repeat (3) @(posedge clk);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
